// File: rtl/spi_pkg.sv
// Shared types and constants for the tick-paced SPI master.
package spi_pkg;
    localparam int unsigned DATA_WIDTH_DEF = 8;
    localparam int unsigned TICK_CNT_W     = 4;

    typedef enum logic [2:0] {IDLE, SETUP, XFER, GAP, HOLD} state_t;
endpackage

// File: rtl/sync2.sv
// Two-flop synchronizer for a single asynchronous input bit.
module sync2 (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);
    logic meta;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end
endmodule

// File: rtl/spi_tick_master.sv
// Mode-0 SPI master whose bit rate is paced by an external prescaler tick.
// Supports bursts: CS_N stays low between words while LAST=0.
module spi_tick_master
    import spi_pkg::*;
#(
    parameter int unsigned DATA_WIDTH  = DATA_WIDTH_DEF,
    parameter int unsigned SETUP_TICKS = 1,
    parameter int unsigned HOLD_TICKS  = 1
) (
    input  logic                  CLK,
    input  logic                  RESETN,
    input  logic                  TICK,
    input  logic                  START,
    input  logic                  LAST,
    input  logic [DATA_WIDTH-1:0] TX_DATA,
    output logic                  READY,
    output logic [DATA_WIDTH-1:0] RX_DATA,
    output logic                  RX_VALID,
    output logic                  CS_N,
    output logic                  SCLK,
    output logic                  MOSI,
    input  logic                  MISO
);
    localparam int unsigned BIT_CNT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [TICK_CNT_W-1:0] SETUP_LAST = TICK_CNT_W'(SETUP_TICKS - 1);
    localparam logic [TICK_CNT_W-1:0] HOLD_LAST  = TICK_CNT_W'(HOLD_TICKS - 1);
    localparam logic [BIT_CNT_W-1:0]  BIT_LAST   = BIT_CNT_W'(DATA_WIDTH - 1);

    state_t                  state_q, state_d;
    logic [TICK_CNT_W-1:0]   tick_cnt_q, tick_cnt_d;
    logic [BIT_CNT_W-1:0]    bit_cnt_q, bit_cnt_d;
    logic [DATA_WIDTH-1:0]   tx_sh_q, tx_sh_d;
    logic [DATA_WIDTH-1:0]   rx_sh_q, rx_sh_d;
    logic [DATA_WIDTH-1:0]   rx_data_d;
    logic                    last_q, last_d;
    logic                    cs_n_d, sclk_d, mosi_d, ready_d, rx_valid_d;
    logic                    miso_s;
    logic                    accept_c;

    sync2 u_miso_sync (
        .clk   (CLK),
        .rst_n (RESETN),
        .d     (MISO),
        .q     (miso_s)
    );

    assign accept_c = START & READY;

    // State and all registered outputs.
    always_ff @(posedge CLK or negedge RESETN) begin
        if (!RESETN) begin
            state_q    <= IDLE;
            tick_cnt_q <= '0;
            bit_cnt_q  <= '0;
            tx_sh_q    <= '0;
            rx_sh_q    <= '0;
            last_q     <= 1'b0;
            CS_N       <= 1'b1;
            SCLK       <= 1'b0;
            MOSI       <= 1'b0;
            READY      <= 1'b1;
            RX_VALID   <= 1'b0;
            RX_DATA    <= '0;
        end else begin
            state_q    <= state_d;
            tick_cnt_q <= tick_cnt_d;
            bit_cnt_q  <= bit_cnt_d;
            tx_sh_q    <= tx_sh_d;
            rx_sh_q    <= rx_sh_d;
            last_q     <= last_d;
            CS_N       <= cs_n_d;
            SCLK       <= sclk_d;
            MOSI       <= mosi_d;
            READY      <= ready_d;
            RX_VALID   <= rx_valid_d;
            RX_DATA    <= rx_data_d;
        end
    end

    // Next-state and next-output logic.
    always_comb begin
        state_d    = state_q;
        tick_cnt_d = tick_cnt_q;
        bit_cnt_d  = bit_cnt_q;
        tx_sh_d    = tx_sh_q;
        rx_sh_d    = rx_sh_q;
        last_d     = last_q;
        cs_n_d     = CS_N;
        sclk_d     = SCLK;
        mosi_d     = MOSI;
        rx_data_d  = RX_DATA;
        rx_valid_d = 1'b0;

        case (state_q)
            IDLE: begin
                if (accept_c) begin
                    tx_sh_d    = TX_DATA;
                    last_d     = LAST;
                    mosi_d     = TX_DATA[DATA_WIDTH-1];
                    cs_n_d     = 1'b0;
                    tick_cnt_d = '0;
                    state_d    = SETUP;
                end
            end
            SETUP: begin
                if (TICK) begin
                    if (tick_cnt_q == SETUP_LAST) begin
                        bit_cnt_d = '0;
                        state_d   = XFER;
                    end else begin
                        tick_cnt_d = tick_cnt_q + TICK_CNT_W'(1);
                    end
                end
            end
            XFER: begin
                if (TICK) begin
                    sclk_d = ~SCLK;
                    if (!SCLK) begin
                        rx_sh_d = {rx_sh_q[DATA_WIDTH-2:0], miso_s};
                    end else if (bit_cnt_q == BIT_LAST) begin
                        rx_data_d  = rx_sh_q;
                        rx_valid_d = 1'b1;
                        tick_cnt_d = '0;
                        state_d    = last_q ? HOLD : GAP;
                    end else begin
                        // Rotate rather than shift so every TX bit stays in use.
                        bit_cnt_d = bit_cnt_q + BIT_CNT_W'(1);
                        tx_sh_d   = {tx_sh_q[DATA_WIDTH-2:0], tx_sh_q[DATA_WIDTH-1]};
                        mosi_d    = tx_sh_q[DATA_WIDTH-2];
                    end
                end
            end
            GAP: begin
                if (accept_c) begin
                    tx_sh_d   = TX_DATA;
                    last_d    = LAST;
                    mosi_d    = TX_DATA[DATA_WIDTH-1];
                    bit_cnt_d = '0;
                    state_d   = XFER;
                end
            end
            HOLD: begin
                if (TICK) begin
                    if (tick_cnt_q == HOLD_LAST) begin
                        cs_n_d  = 1'b1;
                        state_d = IDLE;
                    end else begin
                        tick_cnt_d = tick_cnt_q + TICK_CNT_W'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        ready_d = (state_d == IDLE) || (state_d == GAP);
    end
endmodule

// File: tb/tb_spi_tick_master.sv
// Scoreboard bench for spi_tick_master: RX words are predicted on issue and
// checked by a monitor on each RX_VALID pulse.
module tb_spi_tick_master;
    logic       CLK = 1'b0;
    logic       RESETN = 1'b0;
    logic       TICK = 1'b0;
    logic       START = 1'b0;
    logic       LAST = 1'b0;
    logic [7:0] TX_DATA = 8'h00;
    logic       READY, RX_VALID, CS_N, SCLK, MOSI, MISO;
    logic [7:0] RX_DATA;

    logic       miso_one = 1'b0;
    logic       tick_en = 1'b1;
    int         tick_div = 0;
    int         checks = 0;
    int         failures = 0;
    logic [7:0] exp_q[$];
    logic [7:0] exp_val;
    int         sclk_rises = 0;
    int         rx_pulses = 0;
    int         cs_rises = 0;
    logic [15:0] mosi_bits = 16'h0;

    assign MISO = miso_one ? 1'b1 : MOSI;

    spi_tick_master #(.DATA_WIDTH(8), .SETUP_TICKS(1), .HOLD_TICKS(1)) dut (
        .CLK(CLK), .RESETN(RESETN), .TICK(TICK), .START(START), .LAST(LAST),
        .TX_DATA(TX_DATA), .READY(READY), .RX_DATA(RX_DATA), .RX_VALID(RX_VALID),
        .CS_N(CS_N), .SCLK(SCLK), .MOSI(MOSI), .MISO(MISO)
    );

    always #5 CLK = ~CLK;

    // One TICK every 4 CLK, changed on the falling edge.
    always @(negedge CLK) begin
        tick_div = (tick_div == 3) ? 0 : tick_div + 1;
        TICK = tick_en && (tick_div == 0);
    end

    always @(posedge SCLK) begin
        sclk_rises++;
        mosi_bits = {mosi_bits[14:0], MOSI};
    end

    always @(posedge CS_N) cs_rises++;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    task automatic fail_timeout(input string name);
        checks++;
        failures++;
        $display("FAIL %s timed out", name);
    endtask

    // RX monitor: pops the predicted word on every RX_VALID pulse.
    always @(negedge CLK) begin
        if (RX_VALID === 1'b1) begin
            rx_pulses++;
            if (exp_q.size() == 0) begin
                chk("rx_unexpected_pulse", exp_q.size(), 1);
            end else begin
                exp_val = exp_q.pop_front();
                chk("rx_data", RX_DATA, exp_val);
            end
        end
    end

    task automatic clear_mon();
        sclk_rises = 0;
        rx_pulses  = 0;
        cs_rises   = 0;
        mosi_bits  = 16'h0;
    endtask

    task automatic start_word(input logic [7:0] tx, input logic last);
        int n = 0;
        @(negedge CLK);
        while (!READY && n < 2000) begin
            @(negedge CLK);
            n++;
        end
        if (!READY) fail_timeout("ready_wait");
        START = 1'b1;
        TX_DATA = tx;
        LAST = last;
        @(posedge CLK);
        #1 chk("cs_low_after_accept", CS_N, 0);
        @(negedge CLK);
        START = 1'b0;
        LAST = 1'b0;
    endtask

    task automatic finish_word(input logic last, output int ticks);
        logic done = 1'b0;
        ticks = 0;
        for (int n = 0; n < 3000 && !done; n++) begin
            @(posedge CLK);
            if (TICK) ticks++;
            #1;
            done = last ? CS_N : READY;
        end
        if (!done) fail_timeout("word_finish");
    endtask

    task automatic wait_rises(input int k);
        logic done = 1'b0;
        for (int n = 0; n < 3000 && !done; n++) begin
            @(negedge CLK);
            done = (sclk_rises >= k);
        end
        if (!done) fail_timeout("sclk_rise_wait");
    endtask

    initial begin
        int t1, t2;
        logic frz_sclk, frz_mosi, frz_cs;
        int changed;

        // 1: reset values
        repeat (3) @(posedge CLK);
        #1;
        chk("rst_cs_n", CS_N, 1);
        chk("rst_sclk", SCLK, 0);
        chk("rst_mosi", MOSI, 0);
        chk("rst_ready", READY, 1);
        chk("rst_rx_valid", RX_VALID, 0);
        chk("rst_rx_data", RX_DATA, 8'h00);
        @(negedge CLK);
        RESETN = 1'b1;
        repeat (4) @(negedge CLK);
        clear_mon();

        // 2: single word loopback
        exp_q.push_back(8'hA5);
        start_word(8'hA5, 1'b1);
        finish_word(1'b1, t1);
        chk("single_ticks_to_cs_high", t1, 18);
        chk("single_sclk_pulses", sclk_rises, 8);
        chk("single_mosi_bits", mosi_bits[7:0], 8'hA5);
        chk("single_rx_pulses", rx_pulses, 1);

        // 3: burst with MISO tied high
        repeat (8) @(negedge CLK);
        clear_mon();
        miso_one = 1'b1;
        exp_q.push_back(8'hFF);
        exp_q.push_back(8'hFF);
        start_word(8'h3C, 1'b0);
        finish_word(1'b0, t1);
        chk("burst_w1_ticks", t1, 17);
        chk("burst_gap_cs_low", CS_N, 0);
        start_word(8'hC3, 1'b1);
        finish_word(1'b1, t2);
        chk("burst_w2_ticks", t2, 17);
        chk("burst_sclk_pulses", sclk_rises, 16);
        chk("burst_mosi_bits", mosi_bits, 16'h3CC3);
        chk("burst_cs_rises", cs_rises, 1);
        chk("burst_rx_pulses", rx_pulses, 2);
        miso_one = 1'b0;

        // 4: START while busy is ignored
        repeat (8) @(negedge CLK);
        clear_mon();
        exp_q.push_back(8'hF0);
        start_word(8'hF0, 1'b1);
        wait_rises(2);
        chk("busy_ready_low", READY, 0);
        START = 1'b1;
        TX_DATA = 8'h00;
        @(negedge CLK);
        START = 1'b0;
        finish_word(1'b1, t1);
        chk("busy_mosi_bits", mosi_bits[7:0], 8'hF0);
        repeat (100) @(negedge CLK);
        chk("busy_no_second_xfer", sclk_rises, 8);
        chk("busy_cs_high", CS_N, 1);
        chk("busy_rx_pulses", rx_pulses, 1);

        // 5: reset mid-transfer, then a clean word
        clear_mon();
        start_word(8'h96, 1'b1);
        wait_rises(5);
        #2 RESETN = 1'b0;
        #1;
        chk("midrst_cs_n", CS_N, 1);
        chk("midrst_sclk", SCLK, 0);
        repeat (3) @(negedge CLK);
        chk("midrst_rx_data", RX_DATA, 8'h00);
        RESETN = 1'b1;
        repeat (4) @(negedge CLK);
        chk("midrst_rx_pulses", rx_pulses, 0);
        clear_mon();
        exp_q.push_back(8'h5A);
        start_word(8'h5A, 1'b1);
        finish_word(1'b1, t1);
        chk("postrst_ticks", t1, 18);
        chk("postrst_mosi_bits", mosi_bits[7:0], 8'h5A);
        chk("postrst_rx_pulses", rx_pulses, 1);

        // 6: TICK suppression mid-transfer
        repeat (8) @(negedge CLK);
        clear_mon();
        exp_q.push_back(8'h69);
        start_word(8'h69, 1'b1);
        wait_rises(3);
        @(posedge CLK);
        #2 tick_en = 1'b0;
        repeat (3) @(negedge CLK);
        frz_sclk = SCLK;
        frz_mosi = MOSI;
        frz_cs   = CS_N;
        changed  = 0;
        repeat (50) begin
            @(negedge CLK);
            if (SCLK !== frz_sclk || MOSI !== frz_mosi || CS_N !== frz_cs) changed++;
        end
        chk("freeze_outputs_changed", changed, 0);
        chk("freeze_cs_low", frz_cs, 0);
        #2 tick_en = 1'b1;
        finish_word(1'b1, t1);
        chk("freeze_sclk_pulses", sclk_rises, 8);
        chk("freeze_mosi_bits", mosi_bits[7:0], 8'h69);
        chk("freeze_rx_pulses", rx_pulses, 1);

        // Ticks in IDLE must not move SCLK
        clear_mon();
        repeat (40) @(negedge CLK);
        chk("idle_tick_rises", sclk_rises, 0);
        chk("idle_sclk", SCLK, 0);
        chk("idle_cs_n", CS_N, 1);
        chk("idle_ready", READY, 1);

        chk("scoreboard_empty", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog expired");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1);
    end
endmodule
